// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param: vending FSM with configurable price, exact change, refund and acked outputs.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC idle cycles in COLLECT.
module vending_ctrl_param #(
  parameter int PRICE       = 25,
  parameter int CREDIT_W    = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  input  logic                dispense_ack,
  input  logic                change_ack,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VEND    = 3'd2,
    CHANGE  = 3'd3,
    REFUND  = 3'd4
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] next_credit;
  logic                coin_acc;
  logic                timeout;

  always_comb begin
    coin_val = '0;
    unique case (coin_type)
      2'b01: coin_val = CREDIT_W'(5);
      2'b10: coin_val = CREDIT_W'(10);
      2'b11: coin_val = CREDIT_W'(20);
      2'b00: coin_val = '0;
    endcase
  end

  // cancel in COLLECT takes priority over a coin on the same edge
  assign coin_acc = coin_valid && (coin_type != 2'b00) &&
                    ((state == IDLE) || (state == COLLECT && !cancel));
  assign next_credit = credit + coin_val;
  assign state_out   = state;

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;

  assign timeout = (state == COLLECT) &&
                   (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state != COLLECT || coin_acc) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      credit       <= '0;
    end else begin
      coin_reject <= coin_valid && !coin_acc;
      case (state)
        IDLE, COLLECT: begin
          if (coin_acc) begin
            credit <= next_credit;
            if (next_credit >= PRICE_C) begin
              state      <= VEND;
              dispense   <= 1'b1;
              change_amt <= next_credit - PRICE_C;
            end else begin
              state <= COLLECT;
            end
          end else if (state == COLLECT && (cancel || timeout)) begin
            state        <= REFUND;
            change_valid <= 1'b1;
            change_amt   <= credit;
          end
        end
        VEND: begin
          if (dispense_ack) begin
            dispense <= 1'b0;
            if (change_amt != '0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
            end else begin
              state  <= IDLE;
              credit <= '0;
            end
          end
        end
        CHANGE, REFUND: begin
          if (change_ack) begin
            state        <= IDLE;
            change_valid <= 1'b0;
            change_amt   <= '0;
            credit       <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          dispense     <= 1'b0;
          change_valid <= 1'b0;
          change_amt   <= '0;
          credit       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_ctrl_param.sv
// tb_vending_ctrl_param: directed scenarios plus random traffic against a transaction model.
// Timeout scenario follows VEND_TIMEOUT_EN.
module tb_vending_ctrl_param;

  localparam int PRICE = 25;
  localparam int CW    = 6;
  localparam int TMO   = 8;
  localparam int S_IDLE = 0, S_COLLECT = 1, S_VEND = 2;
  localparam int S_CHANGE = 3, S_REFUND = 4;
`ifdef VEND_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin_type = 2'b00;
  logic          cancel = 1'b0;
  logic          dispense_ack = 1'b0;
  logic          change_ack = 1'b0;
  logic          dispense, change_valid, coin_reject;
  logic [CW-1:0] change_amt, credit;
  logic [2:0]    state_out;

  int tests = 0;
  int fails = 0;

  int m_state, m_credit, m_amt, cyc, last_coin;
  bit m_disp, m_cv, m_rej;

  always #5 clk = ~clk;

  vending_ctrl_param #(
    .PRICE(PRICE), .CREDIT_W(CW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel),
    .dispense_ack(dispense_ack), .change_ack(change_ack),
    .dispense(dispense), .change_valid(change_valid),
    .change_amt(change_amt), .coin_reject(coin_reject),
    .credit(credit), .state_out(state_out)
  );

  function automatic logic [17:0] dut_vec();
    return {state_out, dispense, change_valid,
            change_amt, coin_reject, credit};
  endfunction

  function automatic logic [17:0] mdl_vec();
    return {3'(m_state), m_disp, m_cv,
            CW'(m_amt), m_rej, CW'(m_credit)};
  endfunction

  // one clock: drive inputs, advance the transaction model, settle
  task automatic step(input bit r, input bit cv,
                      input bit [1:0] ct, input bit can,
                      input bit da, input bit ca);
    int v;
    bit acc;
    rst = r; coin_valid = cv; coin_type = ct;
    cancel = can; dispense_ack = da; change_ack = ca;
    @(posedge clk);
    cyc++;
    v = (ct == 2'b01) ? 5 : (ct == 2'b10) ? 10 :
        (ct == 2'b11) ? 20 : 0;
    m_rej = 1'b0;
    if (r) begin
      m_state = S_IDLE; m_credit = 0; m_amt = 0;
      m_disp = 1'b0; m_cv = 1'b0; last_coin = cyc;
    end else begin
      acc = cv && v != 0 &&
            (m_state == S_IDLE ||
             (m_state == S_COLLECT && !can));
      m_rej = cv && !acc;
      if (acc) begin
        m_credit += v;
        last_coin = cyc;
        if (m_credit >= PRICE) begin
          m_state = S_VEND;
          m_disp  = 1'b1;
          m_amt   = m_credit - PRICE;
        end else begin
          m_state = S_COLLECT;
        end
      end else if (m_state == S_COLLECT &&
                   (can || (TMO_EN && cyc - last_coin == TMO))) begin
        m_state = S_REFUND; m_cv = 1'b1; m_amt = m_credit;
      end else if (m_state == S_VEND && da) begin
        m_disp = 1'b0;
        if (m_amt != 0) begin
          m_state = S_CHANGE; m_cv = 1'b1;
        end else begin
          m_state = S_IDLE; m_credit = 0;
        end
      end else if ((m_state == S_CHANGE || m_state == S_REFUND) && ca) begin
        m_state = S_IDLE; m_cv = 1'b0;
        m_amt = 0; m_credit = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    tests++;
    if (dut_vec() !== 18'h0) begin
      $display("FAIL reset: got %h want 0", dut_vec());
      fails++;
    end
  endtask

  task automatic test_exact_vend();
    bit cv_seen = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 0, 0, 0);
    tests++;
    if ({state_out, dispense, credit, change_amt} !==
        {3'd2, 1'b1, 6'd25, 6'd0}) begin
      $display("FAIL exact_vend: got st=%0d d=%b cr=%0d amt=%0d want 2 1 25 0",
               state_out, dispense, credit, change_amt);
      fails++;
    end
    cv_seen |= change_valid;
    step(0, 0, 0, 0, 1, 0);
    cv_seen |= change_valid;
    step(0, 0, 0, 0, 0, 0);
    cv_seen |= change_valid;
    tests++;
    if ({state_out, credit, dispense, cv_seen} !== {3'd0, 6'd0, 1'b0, 1'b0}) begin
      $display("FAIL exact_ack: got st=%0d cr=%0d d=%b cvseen=%b want 0 0 0 0",
               state_out, credit, dispense, cv_seen);
      fails++;
    end
  endtask

  task automatic test_change();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2'b11, 0, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0);
    tests++;
    if ({state_out, dispense} !== {3'd2, 1'b1}) begin
      $display("FAIL change_vend: got st=%0d d=%b want 2 1", state_out, dispense);
      fails++;
    end
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({state_out, change_valid, change_amt, dispense} !==
          {3'd3, 1'b1, 6'd5, 1'b0}) begin
        $display("FAIL change_hold: got st=%0d cv=%b amt=%0d want 3 1 5",
                 state_out, change_valid, change_amt);
        fails++;
      end
      step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 1);
    tests++;
    if ({state_out, credit, change_valid, change_amt} !==
        {3'd0, 6'd0, 1'b0, 6'd0}) begin
      $display("FAIL change_ack: got st=%0d cr=%0d cv=%b amt=%0d want 0 0 0 0",
               state_out, credit, change_valid, change_amt);
      fails++;
    end
  endtask

  task automatic test_cancel();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    tests++;
    if ({state_out, change_valid, change_amt, dispense} !==
        {3'd4, 1'b1, 6'd10, 1'b0}) begin
      $display("FAIL cancel: got st=%0d cv=%b amt=%0d d=%b want 4 1 10 0",
               state_out, change_valid, change_amt, dispense);
      fails++;
    end
    step(0, 0, 0, 0, 0, 1);
    tests++;
    if (dut_vec() !== mdl_vec() || state_out !== 3'd0) begin
      $display("FAIL cancel_ack: got %h want %h", dut_vec(), mdl_vec());
      fails++;
    end
  endtask

  task automatic test_cancel_coin();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0);
    step(0, 1, 2'b01, 0, 0, 0);
    step(0, 1, 2'b11, 1, 0, 0);
    tests++;
    if ({state_out, change_amt, coin_reject, credit} !==
        {3'd4, 6'd15, 1'b1, 6'd15}) begin
      $display("FAIL cancel_coin: got st=%0d amt=%0d rej=%b cr=%0d want 4 15 1 15",
               state_out, change_amt, coin_reject, credit);
      fails++;
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 2'b00, 0, 0, 0);
    tests++;
    if ({coin_reject, credit, state_out} !== {1'b1, 6'd0, 3'd0}) begin
      $display("FAIL bad_coin: got rej=%b cr=%0d st=%0d want 1 0 0",
               coin_reject, credit, state_out);
      fails++;
    end
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if (coin_reject !== 1'b0) begin
      $display("FAIL rej_pulse: got %b want 0", coin_reject);
      fails++;
    end
  endtask

  task automatic test_busy_reject_and_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2'b11, 0, 0, 0);
    step(0, 1, 2'b10, 0, 1, 0);
    tests++;
    if ({state_out, dispense} !== {3'd2, 1'b1}) begin
      $display("FAIL ack_on_rise: got st=%0d d=%b want 2 1", state_out, dispense);
      fails++;
    end
    step(0, 1, 2'b11, 0, 0, 0);
    tests++;
    if ({coin_reject, credit, change_amt, dispense} !==
        {1'b1, 6'd30, 6'd5, 1'b1}) begin
      $display("FAIL vend_reject: got rej=%b cr=%0d amt=%0d d=%b want 1 30 5 1",
               coin_reject, credit, change_amt, dispense);
      fails++;
    end
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    tests++;
    if (dut_vec() !== 18'h0) begin
      $display("FAIL reset_in_change: got %h want 0", dut_vec());
      fails++;
    end
  endtask

  task automatic test_timeout();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 0, 0, 0);
`ifdef VEND_TIMEOUT_EN
    for (int i = 1; i < TMO; i++) step(0, 0, 0, 0, 0, 0);
    tests++;
    if (state_out !== 3'd1) begin
      $display("FAIL tmo_early: got st=%0d want 1", state_out);
      fails++;
    end
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if ({state_out, change_valid, change_amt} !== {3'd4, 1'b1, 6'd5}) begin
      $display("FAIL tmo_fire: got st=%0d cv=%b amt=%0d want 4 1 5",
               state_out, change_valid, change_amt);
      fails++;
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 0, 0, 0);
    for (int i = 1; i < 6; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 0, 0, 0);
    for (int i = 1; i < TMO; i++) step(0, 0, 0, 0, 0, 0);
    tests++;
    if ({state_out, credit} !== {3'd1, 6'd10}) begin
      $display("FAIL tmo_restart: got st=%0d cr=%0d want 1 10", state_out, credit);
      fails++;
    end
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if ({state_out, change_amt} !== {3'd4, 6'd10}) begin
      $display("FAIL tmo_refire: got st=%0d amt=%0d want 4 10", state_out, change_amt);
      fails++;
    end
`else
    for (int i = 0; i < 4 * TMO; i++) step(0, 0, 0, 0, 0, 0);
    tests++;
    if ({state_out, credit, change_valid} !== {3'd1, 6'd5, 1'b0}) begin
      $display("FAIL no_tmo: got st=%0d cr=%0d cv=%b want 1 5 0",
               state_out, credit, change_valid);
      fails++;
    end
`endif
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2'b11, 0, 0, 0);
    step(0, 1, 2'b11, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 2'b11, 0, 0, 0);
    tests++;
    if ({state_out, credit, coin_reject} !== {3'd1, 6'd20, 1'b0}) begin
      $display("FAIL back_to_back: got st=%0d cr=%0d rej=%b want 1 20 0",
               state_out, credit, coin_reject);
      fails++;
    end
    step(0, 1, 2'b10, 0, 0, 0);
    tests++;
    if (dut_vec() !== mdl_vec() || change_amt !== 6'd5) begin
      $display("FAIL b2b_vend: got %h want %h", dut_vec(), mdl_vec());
      fails++;
    end
  endtask

  task automatic test_random();
    int bad = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(99) < 2,
           $urandom_range(99) < 35,
           2'($urandom_range(3)),
           $urandom_range(99) < 8,
           $urandom_range(99) < 40,
           $urandom_range(99) < 40);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    cyc = 0;
    last_coin = 0;
    test_reset();
    test_exact_vend();
    test_change();
    test_cancel();
    test_cancel_coin();
    test_busy_reject_and_reset();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
